// File: rtl/life_engine.sv
// life_engine: Conway's Life engine with a double-buffered board, stepped per frame or on demand.
// Ports: clk, rst_n (sync, active-low); frame_tick/run/step/clear control pulses and level;
//        rd_addr/rd_cell combinational display read of the current board;
//        busy high during COMPUTE/COMMIT; gen_count counts committed generations.
module life_engine #(
  parameter int W_LOG2     = 4,
  parameter int H_LOG2     = 4,
  parameter int GEN_FRAMES = 6,
  parameter int WRAP       = 0
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     frame_tick,
  input  logic                     run,
  input  logic                     step,
  input  logic                     clear,
  input  logic [W_LOG2+H_LOG2-1:0] rd_addr,
  output logic                     rd_cell,
  output logic                     busy,
  output logic [15:0]              gen_count
);
  localparam int AW   = W_LOG2 + H_LOG2;
  localparam int SIZE = 2 ** AW;
  localparam int W    = 2 ** W_LOG2;
  localparam logic [SIZE-1:0] GLIDER = (SIZE'(1) << 1) | (SIZE'(1) << (W + 2)) |
    (SIZE'(1) << (2 * W)) | (SIZE'(1) << (2 * W + 1)) | (SIZE'(1) << (2 * W + 2));
  typedef enum logic [1:0] {SEED, IDLE, COMPUTE, COMMIT} state_t;
  state_t            state_q;
  logic [SIZE-1:0]   cur_q, nxt_q;
  logic [AW-1:0]     idx_q;
  logic [7:0]        frame_q;
  logic [15:0]       gen_q;
  logic              busy_q;
  logic [H_LOG2-1:0] row;
  logic [W_LOG2-1:0] col;
  logic [3:0]        cnt;
  logic              alive_d, start;
  assign row       = idx_q[AW-1:W_LOG2];
  assign col       = idx_q[W_LOG2-1:0];
  assign rd_cell   = cur_q[rd_addr];
  assign busy      = busy_q;
  assign gen_count = gen_q;
  // Adding -1 truncated to the coordinate width wraps modulo the board size;
  // without WRAP the edge tests mask neighbours that fell off the board.
  always_comb begin
    cnt = '0;
    for (int dr = -1; dr <= 1; dr++) begin
      for (int dc = -1; dc <= 1; dc++) begin
        logic [H_LOG2-1:0] rr;
        logic [W_LOG2-1:0] cc;
        logic              inb;
        rr  = row + dr[H_LOG2-1:0];
        cc  = col + dc[W_LOG2-1:0];
        inb = (WRAP != 0) || !((dr < 0 && row == '0) || (dr > 0 && row == '1) ||
                               (dc < 0 && col == '0) || (dc > 0 && col == '1));
        cnt = cnt + (((dr != 0 || dc != 0) && inb) ? 4'(cur_q[{rr, cc}]) : 4'd0);
      end
    end
  end
  assign alive_d = (cnt == 4'd3) || (cnt == 4'd2 && cur_q[idx_q]);
  assign start   = run ? (frame_tick && frame_q == 8'(GEN_FRAMES - 1)) : step;
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q <= SEED;
      cur_q   <= '0;
      nxt_q   <= '0;
      idx_q   <= '0;
      frame_q <= '0;
      gen_q   <= '0;
      busy_q  <= 1'b0;
    end else if (clear && state_q != SEED) begin
      state_q <= IDLE;
      cur_q   <= '0;
      nxt_q   <= '0;
      idx_q   <= '0;
      frame_q <= '0;
      gen_q   <= '0;
      busy_q  <= 1'b0;
    end else begin
      case (state_q)
        SEED: begin
          cur_q   <= GLIDER;
          state_q <= IDLE;
        end
        IDLE: begin
          if (start) begin
            state_q <= COMPUTE;
            idx_q   <= '0;
            frame_q <= '0;
            busy_q  <= 1'b1;
          end else if (run && frame_tick) begin
            frame_q <= frame_q + 8'd1;
          end
        end
        COMPUTE: begin
          nxt_q[idx_q] <= alive_d;
          idx_q        <= idx_q + AW'(1);
          if (idx_q == '1) state_q <= COMMIT;
        end
        COMMIT: begin
          cur_q   <= nxt_q;
          gen_q   <= gen_q + 16'd1;
          busy_q  <= 1'b0;
          state_q <= IDLE;
        end
      endcase
    end
  end
endmodule
